// File: rtl/hazard_ctrl_v2_pkg.sv
// Shared constants for the hazard/forwarding controller: operand-mux encoding,
// register-file defaults and internal counter widths.
package hazard_ctrl_v2_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int X0_ADDR    = 0;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Wide enough for MC_LAT-1 up to 14 and BR_PENALTY-1 up to 6.
  localparam int MC_CNT_W  = 4;
  localparam int PEN_CNT_W = 3;

  // Youngest producer wins.
  function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem,
                                          input logic hit_wb);
    logic [1:0] sel;
    if (hit_ex) begin
      sel = FWD_EX;
    end else if (hit_mem) begin
      sel = FWD_MEM;
    end else if (hit_wb) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Event counter that increments on request and sticks at all-ones.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold at saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl_v2.sv
// Hazard and forwarding controller for the 5-stage core: operand forwarding,
// load-use / RAW stalls, multi-cycle EX busy tracking and redirect flushes.
module hazard_ctrl_v2
  import hazard_ctrl_v2_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int FWD_EN     = 1,
  parameter int BR_PENALTY = 1,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_reg_wen,
  input  logic              mem_reg_wen,
  input  logic              wb_reg_wen,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic              ex_mc_start,
  output logic              stall,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mc_busy,
  output logic              proto_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  function automatic logic reg_hit(input logic wen, input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] src, input logic used);
    return wen && used && (src != REG_AW'(X0_ADDR)) && (rd == src);
  endfunction

  logic                 mc_busy_q, mc_busy_d;
  logic [MC_CNT_W-1:0]  mc_cnt_q, mc_cnt_d;
  logic [PEN_CNT_W-1:0] pen_q, pen_d;
  logic                 proto_err_q, proto_err_d;

  logic hit_ex_a_s, hit_mem_a_s, hit_wb_a_s;
  logic hit_ex_b_s, hit_mem_b_s, hit_wb_b_s;
  logic raw_stall_s, stall_s, flush_id_s, flush_ex_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  // Source matches, operand mux selects and stall/flush priority.
  always_comb begin
    hit_ex_a_s  = reg_hit(ex_reg_wen,  ex_rd,  id_rs1, id_rs1_used);
    hit_mem_a_s = reg_hit(mem_reg_wen, mem_rd, id_rs1, id_rs1_used);
    hit_wb_a_s  = reg_hit(wb_reg_wen,  wb_rd,  id_rs1, id_rs1_used);
    hit_ex_b_s  = reg_hit(ex_reg_wen,  ex_rd,  id_rs2, id_rs2_used);
    hit_mem_b_s = reg_hit(mem_reg_wen, mem_rd, id_rs2, id_rs2_used);
    hit_wb_b_s  = reg_hit(wb_reg_wen,  wb_rd,  id_rs2, id_rs2_used);
    fwd_a_s     = FWD_RF;
    fwd_b_s     = FWD_RF;
    raw_stall_s = 1'b0;
    if (FWD_EN != 0) begin
      fwd_a_s     = fwd_pick(hit_ex_a_s, hit_mem_a_s, hit_wb_a_s);
      fwd_b_s     = fwd_pick(hit_ex_b_s, hit_mem_b_s, hit_wb_b_s);
      raw_stall_s = ex_is_load && (hit_ex_a_s || hit_ex_b_s);
    end else begin
      // WB hits are covered by regfile write-through.
      raw_stall_s = hit_ex_a_s || hit_ex_b_s || hit_mem_a_s || hit_mem_b_s;
    end
    flush_ex_s = ex_redirect;
    flush_id_s = ex_redirect || (pen_q != {PEN_CNT_W{1'b0}});
    // A squashed ID instruction must never hold the pipe.
    if (flush_ex_s) begin
      stall_s = 1'b0;
    end else if (mc_busy_q) begin
      stall_s = 1'b1;
    end else begin
      stall_s = raw_stall_s;
    end
  end

  // Multi-cycle tracker, redirect penalty and protocol-error next state.
  always_comb begin
    mc_busy_d   = mc_busy_q;
    mc_cnt_d    = mc_cnt_q;
    pen_d       = pen_q;
    proto_err_d = proto_err_q;
    if (mc_busy_q) begin
      if (mc_cnt_q == {MC_CNT_W{1'b0}}) begin
        mc_busy_d = 1'b0;
      end else begin
        mc_cnt_d = mc_cnt_q - {{(MC_CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (ex_mc_start && !ex_redirect) begin
      mc_busy_d = 1'b1;
      mc_cnt_d  = MC_CNT_W'(MC_LAT - 1);
    end else begin
      mc_busy_d = 1'b0;
    end
    if (ex_redirect) begin
      pen_d = PEN_CNT_W'(BR_PENALTY - 1);
    end else if (pen_q != {PEN_CNT_W{1'b0}}) begin
      pen_d = pen_q - {{(PEN_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pen_d = pen_q;
    end
    if (ex_mc_start && (mc_busy_q || ex_redirect)) begin
      proto_err_d = 1'b1;
    end else begin
      proto_err_d = proto_err_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_busy_q   <= 1'b0;
      mc_cnt_q    <= {MC_CNT_W{1'b0}};
      pen_q       <= {PEN_CNT_W{1'b0}};
      proto_err_q <= 1'b0;
    end else begin
      mc_busy_q   <= mc_busy_d;
      mc_cnt_q    <= mc_cnt_d;
      pen_q       <= pen_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Combinational outputs are gated so reset forces them low at once.
  assign stall     = rst_n & stall_s;
  assign flush_id  = rst_n & flush_id_s;
  assign flush_ex  = rst_n & flush_ex_s;
  assign fwd_a_sel = rst_n ? fwd_a_s : FWD_RF;
  assign fwd_b_sel = rst_n ? fwd_b_s : FWD_RF;
  assign mc_busy   = mc_busy_q;
  assign proto_err = proto_err_q;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .cnt   (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_id),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Scoreboard bench: two controllers (forwarding and stall-only) share stimulus;
// a cycle-level reference model queues expectations, a monitor checks them.
module tb_hazard_ctrl_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0, mem_rd = 5'd0, wb_rd = 5'd0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       ex_reg_wen = 1'b0, mem_reg_wen = 1'b0, wb_reg_wen = 1'b0;
  logic       ex_is_load = 1'b0, ex_redirect = 1'b0, ex_mc_start = 1'b0;

  logic        a_stall, a_fid, a_fex, a_busy, a_perr;
  logic [1:0]  a_fa, a_fb;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_stall, b_fid, b_fex, b_busy, b_perr;
  logic [1:0]  b_fa, b_fb;
  logic [3:0]  b_scnt, b_fcnt;

  hazard_ctrl_v2 #(.REG_AW(5), .FWD_EN(1), .BR_PENALTY(2), .MC_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_wen(ex_reg_wen), .mem_reg_wen(mem_reg_wen), .wb_reg_wen(wb_reg_wen),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start),
    .stall(a_stall), .flush_id(a_fid), .flush_ex(a_fex),
    .fwd_a_sel(a_fa), .fwd_b_sel(a_fb), .mc_busy(a_busy), .proto_err(a_perr),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  hazard_ctrl_v2 #(.REG_AW(5), .FWD_EN(0), .BR_PENALTY(2), .MC_LAT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_wen(ex_reg_wen), .mem_reg_wen(mem_reg_wen), .wb_reg_wen(wb_reg_wen),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start),
    .stall(b_stall), .flush_id(b_fid), .flush_ex(b_fex),
    .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .mc_busy(b_busy), .proto_err(b_perr),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  typedef struct {
    logic [4:0] rs1, rs2, exrd, memrd, wbrd;
    bit u1, u2, exw, memw, wbw, load, redir, mcs;
  } stim_t;

  typedef struct {
    int stall_a, stall_b, fa, fb, fid, fex, busy, perr, sca, scb, fca, fcb;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state (cycle numbers, not counters of the RTL).
  int cyc = 0;
  int busy_end = -1;
  int flush_end = -1;
  int perr = 0;
  int sca = 0, scb = 0, fca = 0, fcb = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rs1 = 5'd0; s.rs2 = 5'd0; s.exrd = 5'd0; s.memrd = 5'd0; s.wbrd = 5'd0;
    s.u1 = 1'b0; s.u2 = 1'b0; s.exw = 1'b0; s.memw = 1'b0; s.wbw = 1'b0;
    s.load = 1'b0; s.redir = 1'b0; s.mcs = 1'b0;
    return s;
  endfunction

  function automatic bit hits(bit wen, logic [4:0] rd, logic [4:0] src, bit used);
    return wen && used && (src != 5'd0) && (rd == src);
  endfunction

  function automatic int fwd_of(stim_t s, logic [4:0] src, bit used);
    if (hits(s.exw, s.exrd, src, used)) return 1;
    if (hits(s.memw, s.memrd, src, used)) return 2;
    if (hits(s.wbw, s.wbrd, src, used)) return 3;
    return 0;
  endfunction

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic apply(stim_t s);
    id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.exrd; mem_rd = s.memrd; wb_rd = s.wbrd;
    id_rs1_used = s.u1; id_rs2_used = s.u2;
    ex_reg_wen = s.exw; mem_reg_wen = s.memw; wb_reg_wen = s.wbw;
    ex_is_load = s.load; ex_redirect = s.redir; ex_mc_start = s.mcs;
  endtask

  task automatic step(stim_t s);
    exp_t e;
    bit busy_now, ex_any, mem_any;
    @(posedge clk);
    #1;
    apply(s);
    busy_now = (cyc <= busy_end);
    ex_any  = hits(s.exw, s.exrd, s.rs1, s.u1) || hits(s.exw, s.exrd, s.rs2, s.u2);
    mem_any = hits(s.memw, s.memrd, s.rs1, s.u1) || hits(s.memw, s.memrd, s.rs2, s.u2);
    e.fa  = fwd_of(s, s.rs1, s.u1);
    e.fb  = fwd_of(s, s.rs2, s.u2);
    e.fex = s.redir;
    e.fid = (s.redir || cyc <= flush_end) ? 1 : 0;
    e.stall_a = s.redir ? 0 : (busy_now ? 1 : int'(s.load && ex_any));
    e.stall_b = s.redir ? 0 : (busy_now ? 1 : int'(ex_any || mem_any));
    e.busy = busy_now;
    e.perr = perr;
    e.sca = sca; e.scb = scb; e.fca = fca; e.fcb = fcb;
    exp_q.push_back(e);
    if (s.mcs && (busy_now || s.redir)) perr = 1;
    else if (s.mcs) busy_end = cyc + 4;
    if (s.redir) flush_end = cyc + 1;
    sca = sat(sca + e.stall_a, 65535);
    scb = sat(scb + e.stall_b, 15);
    fca = sat(fca + e.fid, 65535);
    fcb = sat(fcb + e.fid, 15);
    cyc++;
  endtask

  // Assert reset between edges with hazardous inputs applied; all outputs must read 0.
  task automatic reset_mid(stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    rst_n = 1'b0;
    e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    apply(idle());
    rst_n = 1'b1;
    busy_end = -1; flush_end = -1; perr = 0;
    sca = 0; scb = 0; fca = 0; fcb = 0;
    cyc++;
  endtask

  task automatic cmp(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("a_stall", int'(a_stall), e.stall_a);
        cmp("b_stall", int'(b_stall), e.stall_b);
        cmp("a_fwd_a", int'(a_fa), e.fa);
        cmp("a_fwd_b", int'(a_fb), e.fb);
        cmp("b_fwd_a", int'(b_fa), 0);
        cmp("b_fwd_b", int'(b_fb), 0);
        cmp("flush_id", int'(a_fid), e.fid);
        cmp("b_flush_id", int'(b_fid), e.fid);
        cmp("flush_ex", int'(a_fex), e.fex);
        cmp("b_flush_ex", int'(b_fex), e.fex);
        cmp("mc_busy", int'(a_busy), e.busy);
        cmp("b_mc_busy", int'(b_busy), e.busy);
        cmp("proto_err", int'(a_perr), e.perr);
        cmp("b_proto_err", int'(b_perr), e.perr);
        cmp("a_stall_cnt", int'(a_scnt), e.sca);
        cmp("b_stall_cnt", int'(b_scnt), e.scb);
        cmp("a_flush_cnt", int'(a_fcnt), e.fca);
        cmp("b_flush_cnt", int'(b_fcnt), e.fcb);
      end
    end
  end

  initial begin
    stim_t s;
    int wait_cyc;
    // Reset with a forwarding hit and a redirect on the inputs.
    s = idle(); s.exrd = 5'd5; s.exw = 1'b1; s.rs1 = 5'd5; s.u1 = 1'b1; s.redir = 1'b1;
    reset_mid(s);
    // EX forward, then x0 excluded.
    s = idle(); s.exrd = 5'd5; s.exw = 1'b1; s.rs1 = 5'd5; s.u1 = 1'b1; step(s);
    s.exrd = 5'd0; s.rs1 = 5'd0; step(s);
    // EX beats MEM, then MEM, then WB only.
    s = idle(); s.exrd = 5'd7; s.memrd = 5'd7; s.exw = 1'b1; s.memw = 1'b1;
    s.rs2 = 5'd7; s.u2 = 1'b1; step(s);
    s.exw = 1'b0; step(s);
    s.memw = 1'b0; s.wbrd = 5'd7; s.wbw = 1'b1; step(s);
    // Load-use: one stall cycle, then unused source does not stall.
    s = idle(); s.load = 1'b1; s.exrd = 5'd3; s.exw = 1'b1; s.rs1 = 5'd3; s.u1 = 1'b1; step(s);
    step(idle());
    s.u1 = 1'b0; step(s);
    // Multi-cycle op, idle through it, then a start during busy.
    s = idle(); s.mcs = 1'b1; step(s);
    for (int i = 0; i < 5; i++) step(idle());
    step(s);
    step(idle());
    step(s);
    for (int i = 0; i < 5; i++) step(idle());
    // Single redirect.
    s = idle(); s.redir = 1'b1; step(s);
    for (int i = 0; i < 3; i++) step(idle());
    // Redirect together with mc_start.
    s.mcs = 1'b1; step(s);
    for (int i = 0; i < 3; i++) step(idle());
    // Stall-only controller: MEM RAW held long enough to saturate its 4-bit counter.
    s = idle(); s.memrd = 5'd9; s.memw = 1'b1; s.rs2 = 5'd9; s.u2 = 1'b1;
    for (int i = 0; i < 19; i++) step(s);
    step(idle());
    @(negedge clk);
    cmp("b_stall_cnt_sat", int'(b_scnt), 15);
    // Random traffic on a small register set to provoke hits.
    for (int i = 0; i < 1500; i++) begin
      s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
      s.exrd = 5'($urandom_range(0, 3)); s.memrd = 5'($urandom_range(0, 3));
      s.wbrd = 5'($urandom_range(0, 3));
      s.u1 = ($urandom_range(0, 3) != 0); s.u2 = ($urandom_range(0, 3) != 0);
      s.exw = $urandom_range(0, 1); s.memw = $urandom_range(0, 1); s.wbw = $urandom_range(0, 1);
      s.load = ($urandom_range(0, 3) == 0);
      s.redir = ($urandom_range(0, 9) == 0);
      s.mcs = ($urandom_range(0, 11) == 0);
      step(s);
    end
    for (int i = 0; i < 6; i++) step(idle());
    // Reset while the multi-cycle unit is busy.
    s = idle(); s.mcs = 1'b1; step(s);
    step(idle());
    s = idle(); s.load = 1'b1; s.exrd = 5'd3; s.exw = 1'b1; s.rs1 = 5'd3; s.u1 = 1'b1;
    s.redir = 1'b1; s.mcs = 1'b1;
    reset_mid(s);
    for (int i = 0; i < 4; i++) step(idle());
    s = idle(); s.exrd = 5'd2; s.exw = 1'b1; s.rs2 = 5'd2; s.u2 = 1'b1; step(s);
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending expectations", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
